// File: rtl/io_port_bank.sv
// Processor-facing I/O responder: per-channel input FIFOs serve bus reads, and
// per-channel output FIFOs capture bus writes. Producers and consumers use valid/ready streams.
module io_port_bank #(
    parameter int NUBITS = 16,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_in,
    input  logic [$clog2(NUIOIN)-1:0]  addr_in,
    output logic [NUBITS-1:0]          io_in,
    input  logic                       out_en,
    input  logic [$clog2(NUIOOU)-1:0]  addr_out,
    input  logic [NUBITS-1:0]          io_out,
    output logic                       itr,
    input  logic [NUIOIN*NUBITS-1:0]   in_data,
    input  logic [NUIOIN-1:0]          in_valid,
    output logic [NUIOIN-1:0]          in_ready,
    output logic [NUIOOU*NUBITS-1:0]   out_data,
    output logic [NUIOOU-1:0]          out_valid,
    input  logic [NUIOOU-1:0]          out_ready,
    output logic [NUIOIN-1:0]          udf,
    output logic [NUIOOU-1:0]          ovf
);

    localparam int AIW = $clog2(NUIOIN);
    localparam int AOW = $clog2(NUIOOU);
    localparam int PW  = $clog2(FDEPTH);
    localparam int CW  = PW + 1;

    logic [NUBITS-1:0] in_show [NUIOIN];
    logic [NUIOIN-1:0] in_ne;
    logic              itr_q;

    for (genvar k = 0; k < NUIOIN; k++) begin : g_in
        logic [NUBITS-1:0] mem_q [FDEPTH];
        logic [PW-1:0]     wp_q, rp_q;
        logic [CW-1:0]     cnt_q;
        logic [NUBITS-1:0] last_q;
        logic              udf_q;
        logic              full, empty, push, rd, pop;

        assign full        = (cnt_q == CW'(FDEPTH));
        assign empty       = (cnt_q == '0);
        assign in_ready[k] = !full && !rst;
        assign push        = in_valid[k] && in_ready[k];
        assign rd          = req_in && (addr_in == AIW'(k));
        // A read of an empty channel is an underflow even if a push lands on the same edge.
        assign pop         = rd && !empty;
        assign in_ne[k]    = !empty;
        assign in_show[k]  = empty ? last_q : mem_q[rp_q];
        assign udf[k]      = udf_q;

        always_ff @(posedge clk) begin
            if (push) mem_q[wp_q] <= in_data[k*NUBITS +: NUBITS];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wp_q   <= '0;
                rp_q   <= '0;
                cnt_q  <= '0;
                last_q <= '0;
                udf_q  <= 1'b0;
            end else begin
                if (push) wp_q <= wp_q + 1'b1;
                if (pop) begin
                    rp_q   <= rp_q + 1'b1;
                    last_q <= mem_q[rp_q];
                end
                if (rd && empty) udf_q <= 1'b1;
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
        end
    end

    assign io_in = (32'(addr_in) < NUIOIN) ? in_show[addr_in] : '0;

    for (genvar j = 0; j < NUIOOU; j++) begin : g_out
        logic [NUBITS-1:0] mem_q [FDEPTH];
        logic [PW-1:0]     wp_q, rp_q;
        logic [CW-1:0]     cnt_q;
        logic              ovf_q;
        logic              full, empty, wr, push, pop;

        assign full         = (cnt_q == CW'(FDEPTH));
        assign empty        = (cnt_q == '0);
        assign wr           = out_en && (addr_out == AOW'(j));
        assign pop          = !empty && out_ready[j];
        // A full output FIFO still accepts a write when the consumer frees a slot on the same edge.
        assign push         = wr && (!full || pop);
        assign out_valid[j] = !empty;
        assign out_data[j*NUBITS +: NUBITS] = mem_q[rp_q];
        assign ovf[j]       = ovf_q;

        always_ff @(posedge clk) begin
            if (push) mem_q[wp_q] <= io_out;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (push) wp_q <= wp_q + 1'b1;
                if (pop)  rp_q <= rp_q + 1'b1;
                if (wr && full && !pop) ovf_q <= 1'b1;
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) itr_q <= 1'b0;
        else     itr_q <= |in_ne;
    end

    assign itr = itr_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: a vector table for the input/read path, plus
// hand-written sequences for FIFO fill, overflow, simultaneous push/pop and async reset.
module tb_io_port_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_in = 1'b0;
    logic [0:0]  addr_in = '0;
    logic [15:0] io_in;
    logic        out_en = 1'b0;
    logic [0:0]  addr_out = '0;
    logic [15:0] io_out = '0;
    logic        itr;
    logic [31:0] in_data = '0;
    logic [1:0]  in_valid = '0;
    logic [1:0]  in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready = '0;
    logic [1:0]  udf;
    logic [1:0]  ovf;

    int total = 0;
    int bad   = 0;

    io_port_bank #(.NUBITS(16), .NUIOIN(2), .NUIOOU(2), .FDEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
        .out_en(out_en), .addr_out(addr_out), .io_out(io_out),
        .itr(itr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .udf(udf), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  iv;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        req;
        logic        ain;
        logic [15:0] e_io;
        logic [1:0]  e_rdy;
        logic        e_itr;
        logic [1:0]  e_udf;
    } vec_t;

    vec_t tv [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        tv[0]  = '{2'b10, 16'h0000, 16'h1111, 1'b0, 1'b1, 16'h1111, 2'b11, 1'b0, 2'b00};
        tv[1]  = '{2'b10, 16'h0000, 16'h2222, 1'b0, 1'b1, 16'h1111, 2'b11, 1'b1, 2'b00};
        tv[2]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h2222, 2'b11, 1'b1, 2'b00};
        tv[3]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h2222, 2'b11, 1'b1, 2'b00};
        tv[4]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h2222, 2'b11, 1'b0, 2'b00};
        tv[5]  = '{2'b01, 16'h00AB, 16'h0000, 1'b0, 1'b0, 16'h00AB, 2'b11, 1'b0, 2'b00};
        tv[6]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h00AB, 2'b11, 1'b1, 2'b00};
        tv[7]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h00AB, 2'b11, 1'b0, 2'b01};
        tv[8]  = '{2'b01, 16'h0055, 16'h0000, 1'b1, 1'b0, 16'h0055, 2'b11, 1'b0, 2'b01};
        tv[9]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0055, 2'b11, 1'b1, 2'b01};
        tv[10] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h2222, 2'b11, 1'b0, 2'b11};

        // Reset state while rst is held
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_io_in", 32'(io_in), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_itr", 32'(itr), 32'h0);
        chk("rst_flags", {28'h0, udf, ovf}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'h3);

        // Input path vector table
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid = tv[i].iv;
            in_data  = {tv[i].d1, tv[i].d0};
            req_in   = tv[i].req;
            addr_in  = tv[i].ain;
            tick();
            chk($sformatf("v%0d_io_in", i), 32'(io_in), 32'(tv[i].e_io));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tv[i].e_rdy));
            chk($sformatf("v%0d_itr", i), 32'(itr), 32'(tv[i].e_itr));
            chk($sformatf("v%0d_udf", i), 32'(udf), 32'(tv[i].e_udf));
        end
        @(negedge clk);
        in_valid = '0;
        req_in   = 1'b0;

        // Fill input channel 0 with in_valid held high
        do_reset();
        chk("rst2_udf", 32'(udf), 32'h0);
        addr_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_data  = {16'h0000, 16'hA0 + 16'(i)};
            in_valid = 2'b01;
            tick();
            chk($sformatf("fill%0d_in_ready0", i), 32'(in_ready[0]), (i < 3) ? 32'h1 : 32'h0);
        end
        @(negedge clk);
        in_valid = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_io_in", i), 32'(io_in), 32'hA0 + 32'(i));
            req_in = 1'b1;
            tick();
            if (i == 0) chk("after_read_in_ready0", 32'(in_ready[0]), 32'h1);
        end
        @(negedge clk);
        req_in = 1'b0;
        chk("fifo_empty_no5th_io_in", 32'(io_in), 32'hA3);
        chk("fill_udf", 32'(udf), 32'h0);

        // Overflow on output channel 1, then drain
        addr_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            out_en = 1'b1;
            io_out = 16'hB0 + 16'(i);
            tick();
            chk($sformatf("wr%0d_out_valid", i), 32'(out_valid), 32'h2);
        end
        @(negedge clk);
        out_en = 1'b0;
        chk("ovf_after_5", 32'(ovf), 32'h2);
        out_ready = 2'b10;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("ovf_out%0d_data", i), 32'(out_data[31:16]), 32'hB0 + 32'(i));
            chk($sformatf("ovf_out%0d_valid", i), 32'(out_valid[1]), 32'h1);
            @(negedge clk);
        end
        chk("ovf_drained_valid", 32'(out_valid), 32'h0);
        out_ready = '0;

        // Simultaneous write and pop on a full output FIFO
        do_reset();
        addr_out = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_en = 1'b1;
            io_out = 16'hC0 + 16'(i);
        end
        @(negedge clk);
        io_out    = 16'hC4;
        out_ready = 2'b01;
        tick();
        chk("sim_ovf", 32'(ovf), 32'h0);
        @(negedge clk);
        out_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("sim_out%0d_data", i), 32'(out_data[15:0]), 32'hC1 + 32'(i));
            chk($sformatf("sim_out%0d_valid", i), 32'(out_valid[0]), 32'h1);
            @(negedge clk);
        end
        chk("sim_drained_valid", 32'(out_valid), 32'h0);
        out_ready = '0;

        // Asynchronous reset with three words buffered
        @(negedge clk);
        in_valid = 2'b01;
        in_data  = {16'h0000, 16'hD0};
        out_en   = 1'b1;
        addr_out = 1'b1;
        io_out   = 16'hE0;
        @(negedge clk);
        in_data = {16'h0000, 16'hD1};
        out_en  = 1'b0;
        @(negedge clk);
        in_valid = '0;
        addr_in  = 1'b0;
        tick();
        chk("pre_rst_itr", 32'(itr), 32'h1);
        chk("pre_rst_out_valid", 32'(out_valid), 32'h2);
        chk("pre_rst_io_in", 32'(io_in), 32'hD0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_itr", 32'(itr), 32'h0);
        chk("arst_io_in", 32'(io_in), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("arst_hold_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_rel_in_ready", 32'(in_ready), 32'h3);
        tick();
        chk("arst_rel_out_valid", 32'(out_valid), 32'h0);
        chk("arst_rel_itr", 32'(itr), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
